// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT engine.
//   complex_16   : packed complex sample, 16-bit signed real/imag
//   agu_state_t  : sequencing FSM states of the address-generation unit
//   fft_log2     : constant log2 for power-of-two transform sizes
//   tw_width     : twiddle ROM index width for an N-point transform
//   stage_width  : width of the stage counter for an N-point transform
package fft_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } agu_state_t;

    // Smallest r with 2^r >= n.
    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Twiddle index covers N/2 entries.
    function automatic int tw_width(input int n);
        return (fft_log2(n) > 1) ? fft_log2(n) - 1 : 1;
    endfunction

    // Stage counter must hold 0..L-1.
    function automatic int stage_width(input int n);
        return (fft_log2(n) > 1) ? $clog2(fft_log2(n)) : 1;
    endfunction

endpackage

// File: rtl/fft_agu_delay.sv
// Shift pipe with a valid bit and a common enable.
// Used to delay the butterfly read-address pair into the write-address pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the pipe this cycle (hold all stages when low)
//   in_valid   : valid bit entering stage 0
//   in_data    : WIDTH-bit payload entering stage 0
//   out_valid  : valid bit leaving the last of DEPTH stages
//   out_data   : payload leaving the last of DEPTH stages
module fft_agu_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0][WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            data_reg  <= '0;
        end else if (en) begin
            valid_reg[0] <= in_valid;
            data_reg[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/fft_agu_pipe.sv
// Address-generation and sequencing unit for an in-place radix-2 DIT FFT.
// Issues one butterfly read pair + twiddle index per non-stalled cycle and
// the matching write pair BF_LAT advancing cycles later. A drain phase of
// BF_LAT advancing cycles between stages keeps stage s+1 reads behind the
// last stage s write.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a transform (only accepted in IDLE)
//   stall               : freeze issue and the write pipe this cycle
//   busy                : high while issuing/draining
//   done                : one-cycle completion pulse
//   stage               : current stage 0..L-1
//   rd_valid, rd_addr_a, rd_addr_b, tw_addr : read pair and twiddle index
//   wr_valid, wr_addr_a, wr_addr_b          : delayed write-back pair
//   cycle_cnt           : busy-cycle counter, only when FFT_AGU_PERF_EN
// Optional feature macro: FFT_AGU_PERF_EN
module fft_agu_pipe
    import fft_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int BF_LAT = 3,
    localparam int L      = fft_log2(N),
    localparam int SW     = stage_width(N),
    localparam int TW     = tw_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic          rd_valid,
    output logic [L-1:0]  rd_addr_a,
    output logic [L-1:0]  rd_addr_b,
    output logic [TW-1:0] tw_addr,
    output logic          wr_valid,
    output logic [L-1:0]  wr_addr_a,
    output logic [L-1:0]  wr_addr_b
`ifdef FFT_AGU_PERF_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [L-2:0]  J_LAST  = '1;
    localparam logic [DW-1:0] DR_LAST = DW'(BF_LAT - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(L - 1);

    agu_state_t    state_reg, state_next;
    logic [SW-1:0] stage_reg, stage_next;
    logic [L-2:0]  j_reg, j_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic          issue;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            stage_reg <= '0;
            j_reg     <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            j_reg     <= j_next;
            drain_reg <= drain_next;
        end
    end

    // ---------------- next state / control ----------------
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        j_next     = j_reg;
        drain_next = drain_reg;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                    stage_next = '0;
                    j_next     = '0;
                end
            end
            ST_ISSUE: begin
                busy  = 1'b1;
                issue = ~stall;
                if (!stall) begin
                    if (j_reg == J_LAST) begin
                        j_next     = '0;
                        drain_next = '0;
                        state_next = ST_DRAIN;
                    end else begin
                        j_next = j_reg + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Only advancing cycles move the write pipe, so only they count.
                if (!stall) begin
                    if (drain_reg == DR_LAST) begin
                        drain_next = '0;
                        if (stage_reg == ST_LAST) begin
                            state_next = ST_FINISH;
                        end else begin
                            stage_next = stage_reg + 1'b1;
                            state_next = ST_ISSUE;
                        end
                    end else begin
                        drain_next = drain_reg + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- address arithmetic ----------------
    // a = (grp << (s+1)) | k, b = a | 2^s (bit s of a is always 0),
    // tw = k << (L-1-s). Shifts are done in two steps so the stage counter
    // never needs to represent L.
    logic [L-2:0]  kmask, k, grp;
    logic [L-1:0]  half, addr_a, addr_b;
    logic [SW-1:0] tw_shift;
    logic [TW-1:0] tw;

    always_comb begin
        kmask    = ~({(L-1){1'b1}} << stage_reg);
        k        = j_reg & kmask;
        grp      = j_reg >> stage_reg;
        half     = {{(L-1){1'b0}}, 1'b1} << stage_reg;
        addr_a   = (({1'b0, grp} << stage_reg) << 1) | {1'b0, k};
        addr_b   = addr_a | half;
        tw_shift = ST_LAST - stage_reg;
        tw       = k << tw_shift;
    end

    // Outputs are forced to zero when not valid so idle/reset shows all zeros.
    assign stage     = stage_reg;
    assign rd_valid  = issue;
    assign rd_addr_a = issue ? addr_a : '0;
    assign rd_addr_b = issue ? addr_b : '0;
    assign tw_addr   = issue ? tw     : '0;

    // ---------------- write-address pipe ----------------
    logic           pipe_valid;
    logic [2*L-1:0] pipe_data;

    fft_agu_delay #(
        .WIDTH (2*L),
        .DEPTH (BF_LAT)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~stall),
        .in_valid  (issue),
        .in_data   ({addr_a, addr_b}),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign wr_valid  = pipe_valid & ~stall;
    assign wr_addr_a = wr_valid ? pipe_data[2*L-1:L] : '0;
    assign wr_addr_b = wr_valid ? pipe_data[L-1:0]   : '0;

`ifdef FFT_AGU_PERF_EN
    // Counts every busy cycle including stalls; saturates; held until next start.
    logic [31:0] cycle_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            cycle_cnt_reg <= '0;
        end else if (busy && (cycle_cnt_reg != 32'hFFFF_FFFF)) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end
    assign cycle_cnt = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_fft_agu_pipe.sv
module tb_fft_agu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- N=8, BF_LAT=3 instance ----------------
    logic       rst8, start8, stall8;
    logic       busy8, done8, rv8, wv8;
    logic [1:0] stage8, tw8;
    logic [2:0] ra8, rb8, wa8, wb8;
`ifdef FFT_AGU_PERF_EN
    logic [31:0] cc8, cc32;
`endif

    fft_agu_pipe #(.N(8), .BF_LAT(3)) dut8 (
        .clk(clk), .rst_n(rst8), .start(start8), .stall(stall8),
        .busy(busy8), .done(done8), .stage(stage8),
        .rd_valid(rv8), .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_addr(tw8),
        .wr_valid(wv8), .wr_addr_a(wa8), .wr_addr_b(wb8)
`ifdef FFT_AGU_PERF_EN
        , .cycle_cnt(cc8)
`endif
    );

    // ---------------- N=32, BF_LAT=1 instance ----------------
    logic       rst32, start32, stall32;
    logic       busy32, done32, rv32, wv32;
    logic [2:0] stage32;
    logic [3:0] tw32;
    logic [4:0] ra32, rb32, wa32, wb32;

    fft_agu_pipe #(.N(32), .BF_LAT(1)) dut32 (
        .clk(clk), .rst_n(rst32), .start(start32), .stall(stall32),
        .busy(busy32), .done(done32), .stage(stage32),
        .rd_valid(rv32), .rd_addr_a(ra32), .rd_addr_b(rb32), .tw_addr(tw32),
        .wr_valid(wv32), .wr_addr_a(wa32), .wr_addr_b(wb32)
`ifdef FFT_AGU_PERF_EN
        , .cycle_cnt(cc32)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected read sequence for N=8, BF_LAT=3 without stall.
    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
    } rvec_t;
    rvec_t rtab [12];

    // Per-cycle logs of the N=8 DUT, indexed by cycle relative to start.
    int rv_l [64], a_l [64], b_l [64], tw_l [64];
    int wv_l [64], wa_l [64], wb_l [64];
    int done_l [64], busy_l [64], stage_l [64], cc_l [64];

    task automatic run8(input logic [63:0] smask, input int glitch_c,
                        input int rst_c, input int ncyc);
        for (int c = 0; c < 64; c++) begin
            rv_l[c] = 0; a_l[c] = 0; b_l[c] = 0; tw_l[c] = 0; wv_l[c] = 0;
            wa_l[c] = 0; wb_l[c] = 0; done_l[c] = 0; busy_l[c] = 0;
            stage_l[c] = 0; cc_l[c] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start8 = (c == 0) || (c == glitch_c);
            stall8 = smask[c];
            if (c == rst_c) begin
                rst8 = 1'b0;
                #1;
                chk("async_reset_outputs_zero",
                    int'({busy8, done8, rv8, wv8, stage8, ra8, rb8, tw8, wa8, wb8}), 0);
            end
            if (rst_c >= 0 && c == rst_c + 2) rst8 = 1'b1;
            @(negedge clk);
            rv_l[c] = rv8;  a_l[c] = ra8;  b_l[c] = rb8;  tw_l[c] = tw8;
            wv_l[c] = wv8;  wa_l[c] = wa8; wb_l[c] = wb8;
            done_l[c] = done8; busy_l[c] = busy8; stage_l[c] = stage8;
`ifdef FFT_AGU_PERF_EN
            cc_l[c] = cc8;
`endif
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        stall8 = 1'b0;
    endtask

    // Checks of an unstalled N=8 run against the hand-computed table.
    task automatic check_nostall(input string tag);
        int nrv, nwv, ndone;
        nrv = 0; nwv = 0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_rv_c%0d", tag, rtab[i].cyc), rv_l[rtab[i].cyc], 1);
            chk($sformatf("%s_ra_c%0d", tag, rtab[i].cyc), a_l[rtab[i].cyc], rtab[i].a);
            chk($sformatf("%s_rb_c%0d", tag, rtab[i].cyc), b_l[rtab[i].cyc], rtab[i].b);
            chk($sformatf("%s_tw_c%0d", tag, rtab[i].cyc), tw_l[rtab[i].cyc], rtab[i].tw);
            chk($sformatf("%s_wv_c%0d", tag, rtab[i].cyc + 3), wv_l[rtab[i].cyc + 3], 1);
            chk($sformatf("%s_wa_c%0d", tag, rtab[i].cyc + 3), wa_l[rtab[i].cyc + 3], rtab[i].a);
            chk($sformatf("%s_wb_c%0d", tag, rtab[i].cyc + 3), wb_l[rtab[i].cyc + 3], rtab[i].b);
        end
        for (int c = 0; c < 30; c++) begin
            nrv += rv_l[c];
            nwv += wv_l[c];
            ndone += done_l[c];
        end
        chk({tag, "_read_count"}, nrv, 12);
        chk({tag, "_write_count"}, nwv, 12);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_done_c22"}, done_l[22], 1);
        chk({tag, "_busy_c0"}, busy_l[0], 0);
        chk({tag, "_busy_c1"}, busy_l[1], 1);
        chk({tag, "_busy_c21"}, busy_l[21], 1);
        chk({tag, "_busy_c22"}, busy_l[22], 0);
        chk({tag, "_stage_c8"}, stage_l[8], 1);
        chk({tag, "_stage_c15"}, stage_l[15], 2);
    endtask

    initial begin
        logic [63:0] m;
        int ridx, widx, ndone, nrv, nwv;
        int nrd32, nwr32, dup32, done_at32;
        logic [31:0] seen [5];

        rtab[0]  = '{1, 0, 1, 0};  rtab[1]  = '{2, 2, 3, 0};
        rtab[2]  = '{3, 4, 5, 0};  rtab[3]  = '{4, 6, 7, 0};
        rtab[4]  = '{8, 0, 2, 0};  rtab[5]  = '{9, 1, 3, 2};
        rtab[6]  = '{10, 4, 6, 0}; rtab[7]  = '{11, 5, 7, 2};
        rtab[8]  = '{15, 0, 4, 0}; rtab[9]  = '{16, 1, 5, 1};
        rtab[10] = '{17, 2, 6, 2}; rtab[11] = '{18, 3, 7, 3};

        rst8 = 1'b0; start8 = 1'b0; stall8 = 1'b0;
        rst32 = 1'b0; start32 = 1'b0; stall32 = 1'b0;
        #12;
        chk("reset_state_n8",
            int'({busy8, done8, rv8, wv8, stage8, ra8, rb8, tw8, wa8, wb8}), 0);
        chk("reset_state_n32",
            int'({busy32, done32, rv32, wv32, stage32, ra32, rb32, tw32, wa32, wb32}), 0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        rst32 = 1'b1;
        repeat (2) @(posedge clk);

        // Run A: no stall; stall raised together with start in IDLE must not matter.
        m = '0;
        m[0] = 1'b1;
        run8(m, -1, -1, 30);
        check_nostall("A");

        // Run B: stall in cycles 3-5 and 13.
        m = '0;
        m[3] = 1'b1; m[4] = 1'b1; m[5] = 1'b1; m[13] = 1'b1;
        run8(m, -1, -1, 34);
        ridx = 0; widx = 0; ndone = 0;
        for (int c = 0; c < 34; c++) begin
            if (rv_l[c] != 0) begin
                if (ridx < 12) begin
                    chk($sformatf("B_rd%0d_a", ridx), a_l[c], rtab[ridx].a);
                    chk($sformatf("B_rd%0d_b", ridx), b_l[c], rtab[ridx].b);
                    chk($sformatf("B_rd%0d_tw", ridx), tw_l[c], rtab[ridx].tw);
                end
                ridx++;
            end
            if (wv_l[c] != 0) begin
                if (widx < 12) begin
                    chk($sformatf("B_wr%0d_a", widx), wa_l[c], rtab[widx].a);
                    chk($sformatf("B_wr%0d_b", widx), wb_l[c], rtab[widx].b);
                end
                widx++;
            end
            ndone += done_l[c];
            if (m[c]) begin
                chk($sformatf("B_rv_stalled_c%0d", c), rv_l[c], 0);
                chk($sformatf("B_wv_stalled_c%0d", c), wv_l[c], 0);
            end
        end
        chk("B_read_count", ridx, 12);
        chk("B_write_count", widx, 12);
        chk("B_done_count", ndone, 1);
        chk("B_done_c26", done_l[26], 1);
`ifdef FFT_AGU_PERF_EN
        chk("perf_cnt_at_done", int'(cc_l[26]), 25);
        repeat (5) @(posedge clk);
        #1;
        chk("perf_cnt_holds", int'(cc8), 25);
`endif

        // Run C: start glitch at cycle 6 (ignored), async reset at cycle 10.
        run8('0, 6, 10, 30);
        for (int i = 0; i < 12; i++) begin
            if (rtab[i].cyc < 10) begin
                chk($sformatf("C_ra_c%0d", rtab[i].cyc), a_l[rtab[i].cyc], rtab[i].a);
                chk($sformatf("C_rb_c%0d", rtab[i].cyc), b_l[rtab[i].cyc], rtab[i].b);
                chk($sformatf("C_tw_c%0d", rtab[i].cyc), tw_l[rtab[i].cyc], rtab[i].tw);
            end
        end
        ndone = 0; nrv = 0; nwv = 0;
        for (int c = 0; c < 30; c++) begin
            ndone += done_l[c];
            if (c >= 10) begin
                nrv += rv_l[c];
                nwv += wv_l[c];
            end
        end
        chk("C_no_done", ndone, 0);
        chk("C_no_reads_after_reset", nrv, 0);
        chk("C_no_writes_after_reset", nwv, 0);

        // Restart after reset must complete normally.
        run8('0, -1, -1, 30);
        check_nostall("R");
`ifdef FFT_AGU_PERF_EN
        chk("perf_cnt_cleared_on_start", int'(cc_l[1]), 0);
`endif

        // Run D: N=32, BF_LAT=1.
        nrd32 = 0; nwr32 = 0; dup32 = 0; done_at32 = -1;
        for (int s = 0; s < 5; s++) seen[s] = '0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            start32 = (c == 0);
            @(negedge clk);
            if (rv32) begin
                if (seen[stage32][ra32] || seen[stage32][rb32]) dup32++;
                seen[stage32][ra32] = 1'b1;
                seen[stage32][rb32] = 1'b1;
                nrd32++;
            end
            if (wv32) nwr32++;
            if (done32) begin
                if (done_at32 < 0) done_at32 = c;
                else dup32++;
            end
            if (c == 19) begin
                chk("D_c19_ra", ra32, 1);
                chk("D_c19_rb", rb32, 3);
                chk("D_c19_tw", tw32, 8);
            end
            if (c == 69) begin
                chk("D_c69_ra", ra32, 0);
                chk("D_c69_rb", rb32, 16);
                chk("D_c69_stage", stage32, 4);
            end
        end
        start32 = 1'b0;
        chk("D_read_count", nrd32, 80);
        chk("D_write_count", nwr32, 80);
        chk("D_done_cycle", done_at32, 86);
        chk("D_duplicates", dup32, 0);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("D_stage%0d_permutation", s), int'(seen[s] == 32'hFFFF_FFFF), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
